// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared definitions for the LCD image controller and its
//                command sequencer: 3-bit command codes and the sequencer
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // LCD controller command codes
  localparam logic [2:0] CMD_WRITE    = 3'd0;
  localparam logic [2:0] CMD_UP       = 3'd1;
  localparam logic [2:0] CMD_DOWN     = 3'd2;
  localparam logic [2:0] CMD_LEFT     = 3'd3;
  localparam logic [2:0] CMD_RIGHT    = 3'd4;
  localparam logic [2:0] CMD_AVERAGE  = 3'd5;
  localparam logic [2:0] CMD_MIRROR_X = 3'd6;
  localparam logic [2:0] CMD_MIRROR_Y = 3'd7;

  // Command sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_seq
//  Description : Command initiator for the LCD image controller. Reads a
//                command program from an external command ROM (one-cycle
//                read latency) and issues the commands one at a time on
//                cmd/cmd_valid, honouring busy. After the terminating WRITE
//                it waits for the controller's done.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   clock, rising edge
//    reset      in   asynchronous reset, active low
//    start      in   one-cycle launch pulse, sampled in IDLE only
//    CROM_EN    out  command ROM read enable
//    CROM_A     out  command ROM address [AW-1:0]
//    CROM_Q     in   command ROM data [2:0], valid the cycle after CROM_EN
//    busy       in   LCD controller busy
//    done       in   LCD controller done (level)
//    cmd        out  command code [2:0]
//    cmd_valid  out  one-cycle qualifier for cmd
//    seq_busy   out  sequencer running
//    seq_done   out  program complete (sticky until next accepted start)
//    seq_err    out  ROM end reached without WRITE (sticky)
//    cmd_count  out  commands issued since last accepted start [AW:0]
// ============================================================================
module lcd_cmd_seq #(
  parameter int CMD_DEPTH = 16,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          CROM_EN,
  output logic [AW-1:0] CROM_A,
  input  logic [2:0]    CROM_Q,
  input  logic          busy,
  input  logic          done,
  output logic [2:0]    cmd,
  output logic          cmd_valid,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          seq_err,
  output logic [AW:0]   cmd_count
);

  import lcd_pkg::*;

  localparam logic [AW-1:0] PC_LAST = AW'(CMD_DEPTH - 1);
  localparam logic [AW:0]   CNT_MAX = '1;

  seq_state_t    state, state_nxt;
  logic [AW-1:0] pc, pc_nxt, pc_inc;
  logic [2:0]    cmd_reg, cmd_reg_nxt;
  logic          start_armed;

  logic          crom_en_nxt;
  logic [AW-1:0] crom_a_nxt;
  logic [2:0]    cmd_nxt;
  logic          cmd_valid_nxt;
  logic          seq_busy_nxt;
  logic          seq_done_nxt;
  logic          seq_err_nxt;
  logic [AW:0]   cmd_count_nxt;

  assign pc_inc = pc + AW'(1);

  // start_armed stays low for the first edge after reset release so that a
  // start pulse coinciding with the release is not accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      cmd_reg     <= CMD_WRITE;
      start_armed <= 1'b0;
      CROM_EN     <= 1'b0;
      CROM_A      <= '0;
      cmd         <= CMD_WRITE;
      cmd_valid   <= 1'b0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      seq_err     <= 1'b0;
      cmd_count   <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      cmd_reg     <= cmd_reg_nxt;
      start_armed <= 1'b1;
      CROM_EN     <= crom_en_nxt;
      CROM_A      <= crom_a_nxt;
      cmd         <= cmd_nxt;
      cmd_valid   <= cmd_valid_nxt;
      seq_busy    <= seq_busy_nxt;
      seq_done    <= seq_done_nxt;
      seq_err     <= seq_err_nxt;
      cmd_count   <= cmd_count_nxt;
    end
  end

  // Outputs are registered: each value below becomes visible in the state
  // being entered, so CROM_EN is set on the transition into FETCH.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    cmd_reg_nxt   = cmd_reg;
    crom_en_nxt   = 1'b0;
    crom_a_nxt    = CROM_A;
    cmd_nxt       = cmd;
    cmd_valid_nxt = 1'b0;
    seq_busy_nxt  = seq_busy;
    seq_done_nxt  = seq_done;
    seq_err_nxt   = seq_err;
    cmd_count_nxt = cmd_count;

    case (state)
      ST_IDLE: begin
        if (start && start_armed) begin
          state_nxt     = ST_FETCH;
          pc_nxt        = '0;
          crom_en_nxt   = 1'b1;
          crom_a_nxt    = '0;
          seq_busy_nxt  = 1'b1;
          seq_done_nxt  = 1'b0;
          seq_err_nxt   = 1'b0;
          cmd_count_nxt = '0;
        end
      end

      ST_FETCH: begin
        // ROM read is in flight; data is valid in LATCH.
        state_nxt = ST_LATCH;
      end

      ST_LATCH: begin
        cmd_reg_nxt = CROM_Q;
        state_nxt   = ST_ISSUE;
      end

      ST_ISSUE: begin
        // The cmd_valid term only matters for the automatic WRITE, which
        // would otherwise be issued on the cycle right after the last LEFT.
        if (!busy && !cmd_valid) begin
          cmd_nxt       = cmd_reg;
          cmd_valid_nxt = 1'b1;
          cmd_count_nxt = (cmd_count == CNT_MAX) ? cmd_count
                                                 : cmd_count + (AW+1)'(1);
          if (cmd_reg == CMD_WRITE) begin
            state_nxt = ST_WAIT_DONE;
          end else if (pc == PC_LAST) begin
            cmd_reg_nxt = CMD_WRITE;
            seq_err_nxt = 1'b1;
          end else begin
            pc_nxt      = pc_inc;
            crom_en_nxt = 1'b1;
            crom_a_nxt  = pc_inc;
            state_nxt   = ST_FETCH;
          end
        end
      end

      ST_WAIT_DONE: begin
        if (done) begin
          seq_done_nxt = 1'b1;
          seq_busy_nxt = 1'b0;
          state_nxt    = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_cmd_seq
//  Description : Directed self-checking bench for lcd_cmd_seq, with a
//                behavioural command ROM (lcd_cmd_rom, one-cycle latency)
//                and a hand-driven LCD controller (busy/done).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_seq;

  import lcd_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          crom_en;
  logic [AW-1:0] crom_a;
  logic [2:0]    crom_q;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          seq_busy;
  logic          seq_done;
  logic          seq_err;
  logic [AW:0]   cmd_count;

  logic [2:0]    rom_mem [DEPTH];

  typedef struct {
    int         cyc;
    logic [2:0] c;
  } ev_t;

  ev_t evq[$];
  int  cyc      = 0;
  int  b2b      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;
  logic prev_v  = 1'b0;

  always #5 clk = ~clk;

  lcd_cmd_seq #(.CMD_DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset_n),
    .start     (start),
    .CROM_EN   (crom_en),
    .CROM_A    (crom_a),
    .CROM_Q    (crom_q),
    .busy      (busy),
    .done      (done),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .seq_err   (seq_err),
    .cmd_count (cmd_count)
  );

  // lcd_cmd_rom: behavioural command ROM, data valid the cycle after CROM_EN
  always @(posedge clk) begin
    if (crom_en) crom_q <= rom_mem[crom_a];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Records every issued command with the edge number it appeared after.
  always @(posedge clk) begin
    #1;
    if (cmd_valid === 1'b1) begin
      if (prev_v) b2b = b2b + 1;
      evq.push_back('{cyc: cyc, c: cmd});
    end
    prev_v = (cmd_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_rom(input logic [2:0] fill);
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = fill;
  endtask

  // Pulse start so it is sampled on the next edge; returns that edge number.
  task automatic run_start(output int t);
    evq.delete();
    b2b   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    t     = cyc;
  endtask

  task automatic wait_entries(input int n, input int budget, input string tag);
    int k = 0;
    while (evq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, evq.size(), n);
  endtask

  task automatic check_ev(input int i, input int cyc_exp, input int cmd_exp,
                          input string tag);
    if (i < evq.size()) begin
      check({tag, "_cyc"}, evq[i].cyc, cyc_exp);
      check({tag, "_cmd"}, {29'd0, evq[i].c}, cmd_exp);
    end else begin
      check({tag, "_missing"}, evq.size(), i + 1);
    end
  endtask

  task automatic finish_run(input int exp_count, input logic exp_err,
                            input string tag);
    done = 1'b1;
    tick();
    tick();
    check({tag, "_seq_done"}, seq_done, 1);
    check({tag, "_seq_busy"}, seq_busy, 0);
    check({tag, "_count"}, cmd_count, exp_count);
    check({tag, "_err"}, seq_err, exp_err);
    done = 1'b0;
    busy = 1'b0;
    tick();
  endtask

  initial begin
    int t;
    int e;
    int bad;

    reset_n = 1'b0;
    start   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    load_rom(CMD_MIRROR_Y);

    // ---------------- reset values ----------------
    repeat (3) tick();
    check("rst_crom_en", crom_en, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_seq_busy", seq_busy, 0);
    check("rst_count", cmd_count, 0);

    // start coinciding with reset release is ignored
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("rel_start_busy", seq_busy, 0);
    check("rel_start_en", crom_en, 0);

    // reset mid-FETCH
    load_rom(CMD_MIRROR_Y);
    rom_mem[0] = CMD_RIGHT;
    run_start(t);
    check("fetch_en", crom_en, 1);
    check("fetch_busy", seq_busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", crom_en, 0);
    check("mid_rst_a", crom_a, 0);
    check("mid_rst_busy", seq_busy, 0);
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_cmd", cmd, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) tick();
    check("post_rst_idle", seq_busy, 0);
    check("post_rst_noissue", evq.size(), 0);

    // ---------------- basic program {4,2,5,0} ----------------
    load_rom(CMD_MIRROR_Y);
    rom_mem[0] = CMD_RIGHT;
    rom_mem[1] = CMD_DOWN;
    rom_mem[2] = CMD_AVERAGE;
    rom_mem[3] = CMD_WRITE;
    run_start(t);
    wait_entries(4, 40, "basic_issue");
    check_ev(0, t + 3, 4, "basic0");
    check_ev(1, t + 6, 2, "basic1");
    check_ev(2, t + 9, 5, "basic2");
    check_ev(3, t + 12, 0, "basic3");
    busy = 1'b1;
    repeat (65) tick();
    check("basic_wait_done", seq_done, 0);
    check("basic_wait_busy", seq_busy, 1);
    check("basic_no_extra", evq.size(), 4);
    check("basic_b2b", b2b, 0);
    finish_run(4, 1'b0, "basic");

    // ------------- image-load stall, stale done in ISSUE -------------
    load_rom(CMD_MIRROR_Y);
    rom_mem[0] = CMD_UP;
    rom_mem[1] = CMD_WRITE;
    busy = 1'b1;
    done = 1'b1;
    run_start(t);
    repeat (69) tick();
    check("stall_noissue", evq.size(), 0);
    check("stall_done_ignored", seq_done, 0);
    check("stall_running", seq_busy, 1);
    busy = 1'b0;
    e    = cyc + 1;
    wait_entries(2, 20, "stall_issue");
    check_ev(0, e, 1, "stall0");
    check_ev(1, e + 3, 0, "stall1");
    finish_run(2, 1'b0, "stall");

    // ---------------- no terminator: 16 x LEFT ----------------
    load_rom(CMD_LEFT);
    run_start(t);
    wait_entries(17, 80, "noterm_issue");
    bad = 0;
    for (int i = 0; i < 16 && i < evq.size(); i++)
      if (evq[i].c !== CMD_LEFT || evq[i].cyc != t + 3 * (i + 1)) bad++;
    check("noterm_left_bad", bad, 0);
    check_ev(16, t + 50, 0, "noterm_write");
    check("noterm_err", seq_err, 1);
    check("noterm_count17", cmd_count, 17);
    check("noterm_b2b", b2b, 0);
    finish_run(17, 1'b1, "noterm");

    // ---------------- ignored start during ISSUE ----------------
    load_rom(CMD_MIRROR_Y);
    rom_mem[0] = CMD_MIRROR_X;
    rom_mem[1] = CMD_MIRROR_Y;
    rom_mem[2] = CMD_WRITE;
    run_start(t);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_count", cmd_count, 2);
    check("ign_err", seq_err, 0);
    wait_entries(3, 20, "ign_issue");
    check_ev(0, t + 3, 6, "ign0");
    check_ev(1, t + 6, 7, "ign1");
    check_ev(2, t + 9, 0, "ign2");
    finish_run(3, 1'b0, "ign");

    // ---------------- busy between 2nd and 3rd command ----------------
    load_rom(CMD_MIRROR_Y);
    rom_mem[0] = CMD_UP;
    rom_mem[1] = CMD_DOWN;
    rom_mem[2] = CMD_LEFT;
    rom_mem[3] = CMD_RIGHT;
    rom_mem[4] = CMD_WRITE;
    run_start(t);
    repeat (6) tick();
    busy = 1'b1;
    repeat (10) tick();
    check("mid_busy_held", evq.size(), 2);
    busy = 1'b0;
    wait_entries(5, 30, "mid_issue");
    check_ev(0, t + 3, 1, "mid0");
    check_ev(1, t + 6, 2, "mid1");
    check_ev(2, t + 17, 3, "mid2");
    check_ev(3, t + 20, 4, "mid3");
    check_ev(4, t + 23, 0, "mid4");
    check("mid_b2b", b2b, 0);
    finish_run(5, 1'b0, "mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
